// File: rtl/debounce_botoes.sv
// Four-channel push-button debouncer: two-flop synchronizer, per-channel stability
// counter, registered debounced level and a single-cycle press strobe per channel.
module debounce_botoes #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 21
) (
  input  logic clk,
  input  logic rst,
  input  logic btn1,
  input  logic btn2,
  input  logic btn3,
  input  logic btn4,
  output logic btn1_limpo,
  output logic btn2_limpo,
  output logic btn3_limpo,
  output logic btn4_limpo,
  output logic pulso1,
  output logic pulso2,
  output logic pulso3,
  output logic pulso4
);

  localparam int unsigned      N_CH    = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_CH-1:0]  btn_raw;
  logic [N_CH-1:0]  sync1_q, sync1_d;
  logic [N_CH-1:0]  sync2_q, sync2_d;
  logic [N_CH-1:0]  stable_q, stable_d;
  logic [N_CH-1:0]  pulso_q, pulso_d;
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];

  assign btn_raw = {btn4, btn3, btn2, btn1};

  // Counter only runs while the synchronized input disagrees with the accepted level;
  // any agreement clears it, so partial counts never survive a bounce.
  always_comb begin
    sync1_d  = btn_raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    for (int i = 0; i < int'(N_CH); i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
    // Strobe only on an accepted press (stable level falling).
    pulso_d = stable_q & ~stable_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      stable_q <= '1;
      pulso_q  <= '0;
      for (int i = 0; i < int'(N_CH); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      pulso_q  <= pulso_d;
      for (int i = 0; i < int'(N_CH); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign btn1_limpo = stable_q[0];
  assign btn2_limpo = stable_q[1];
  assign btn3_limpo = stable_q[2];
  assign btn4_limpo = stable_q[3];
  assign pulso1     = pulso_q[0];
  assign pulso2     = pulso_q[1];
  assign pulso3     = pulso_q[2];
  assign pulso4     = pulso_q[3];

endmodule

// File: tb/tb_debounce_botoes.sv
// Bench for debounce_botoes: directed scenarios with literal expectations plus
// random bouncy stimulus compared every cycle against a history-window model.
module tb_debounce_botoes;

  localparam int unsigned D  = 4;
  localparam int unsigned CW = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] btn = 4'hF;
  logic [3:0] limpo;
  logic [3:0] pulso;

  int n_tests = 0;
  int n_fail  = 0;

  debounce_botoes #(.DEBOUNCE_CYCLES(D), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn1       (btn[0]),
    .btn2       (btn[1]),
    .btn3       (btn[2]),
    .btn4       (btn[3]),
    .btn1_limpo (limpo[0]),
    .btn2_limpo (limpo[1]),
    .btn3_limpo (limpo[2]),
    .btn4_limpo (limpo[3]),
    .pulso1     (pulso[0]),
    .pulso2     (pulso[1]),
    .pulso3     (pulso[2]),
    .pulso4     (pulso[3])
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: synchronized value at edge k is the raw value sampled at edge k-2; a level is
  // accepted once the last D synchronized samples (since reset/last acceptance) all differ.
  logic [3:0] m_stable = 4'hF;
  logic [3:0] m_pulse  = 4'h0;
  int         k        = 0;
  int         since [4];
  bit         rawlog [4][16];
  bit         s2log  [4][16];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      k        = 0;
      m_stable = 4'hF;
      m_pulse  = 4'h0;
      for (int ch = 0; ch < 4; ch++) since[ch] = 0;
    end else begin
      k = k + 1;
      for (int ch = 0; ch < 4; ch++) begin
        bit s;
        bit ok;
        rawlog[ch][k % 16] = btn[ch];
        s = (k <= 2) ? 1'b1 : rawlog[ch][(k - 2) % 16];
        s2log[ch][k % 16] = s;
        ok = (k - since[ch] >= int'(D));
        if (ok) begin
          for (int j = 0; j < int'(D); j++) begin
            if (s2log[ch][(k - j) % 16] == m_stable[ch]) ok = 1'b0;
          end
        end
        if (ok) begin
          m_stable[ch] = s;
          m_pulse[ch]  = ~s;
          since[ch]    = k;
        end else begin
          m_pulse[ch] = 1'b0;
        end
      end
    end
  end

  always @(posedge clk) begin
    #2;
    check("limpo_vs_model", 32'(limpo), 32'(m_stable));
    check("pulso_vs_model", 32'(pulso), 32'(m_pulse));
    for (int ch = 0; ch < 4; ch++) begin
      check("cnt_bound", 32'(dut.cnt_q[ch] <= CW'(D - 1)), 32'd1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks 8 edges after an input change: limpo switches and pulse fires at edge 6.
  task automatic expect_accept(input string name, input logic [3:0] lim_before,
                               input logic [3:0] lim_after, input logic [3:0] pul);
    for (int e = 1; e <= 8; e++) begin
      tick();
      check({name, "_limpo"}, 32'(limpo), 32'(e >= 6 ? lim_after : lim_before));
      check({name, "_pulso"}, 32'(pulso), 32'(e == 6 ? pul : 4'h0));
    end
  endtask

  initial begin
    int pc;
    int hold [4];
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_limpo", 32'(limpo), 32'hF);
    check("reset_pulso", 32'(pulso), 32'h0);
    @(negedge clk) rst = 1'b0;
    tick();
    check("post_reset_limpo", 32'(limpo), 32'hF);

    @(negedge clk) btn[0] = 1'b0;
    expect_accept("press1", 4'hF, 4'hE, 4'h1);
    @(negedge clk) btn[0] = 1'b1;
    expect_accept("release1", 4'hE, 4'hF, 4'h0);

    // Bounce on btn2: low 3, high 1, then low steady.
    @(negedge clk) btn[1] = 1'b0;
    repeat (3) begin tick(); check("bounce_glitch", 32'(limpo), 32'hF); end
    @(negedge clk) btn[1] = 1'b1;
    tick();
    check("bounce_glitch", 32'(limpo), 32'hF);
    @(negedge clk) btn[1] = 1'b0;
    expect_accept("bounce2", 4'hF, 4'hD, 4'h2);

    @(negedge clk) btn[3:2] = 2'b00;
    expect_accept("simul34", 4'hD, 4'h1, 4'hC);
    @(negedge clk) btn = 4'hF;
    repeat (10) tick();
    check("all_released", 32'(limpo), 32'hF);

    // Reset in the middle of a btn1 count.
    @(negedge clk) btn[0] = 1'b0;
    repeat (3) tick();
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_limpo", 32'(limpo), 32'hF);
    check("midrst_pulso", 32'(pulso), 32'h0);
    @(negedge clk) rst = 1'b0;
    expect_accept("after_rst", 4'hF, 4'hE, 4'h1);
    @(negedge clk) btn[0] = 1'b1;
    repeat (10) tick();

    // Long hold on btn2.
    @(negedge clk) btn[1] = 1'b0;
    pc = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (pulso[1]) pc++;
    end
    check("hold_pulse_count", 32'(pc), 32'd1);
    check("hold_limpo", 32'(limpo), 32'hD);
    @(negedge clk) btn[1] = 1'b1;
    repeat (10) tick();

    // Random bouncy stimulus with occasional resets.
    for (int ch = 0; ch < 4; ch++) hold[ch] = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      for (int ch = 0; ch < 4; ch++) begin
        if (hold[ch] == 0) begin
          btn[ch]  = ~btn[ch];
          hold[ch] = int'($urandom_range(1, 9));
        end else begin
          hold[ch] = hold[ch] - 1;
        end
      end
      rst = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk) rst = 1'b0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/debounce_botoes.md
DEBOUNCE_BOTOES -- requirements
Module: debounce_botoes

Interface
REQ-001 SHALL provide parameter DEBOUNCE_CYCLES, default 1000000, the number of consecutive stable cycles required before a level is accepted (20 ms at 50 MHz); legal range 2 to 2^CNT_W-1.
REQ-002 SHALL provide parameter CNT_W, default 21, the width of each per-button stability counter.
REQ-003 SHALL have port clk, input, 1, the single system clock; all registers clock on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-005 SHALL have ports btn1..btn4, input, 1 each, raw asynchronous push-buttons, active-low (0 = pressed).
REQ-006 SHALL have ports btn1_limpo..btn4_limpo, output, 1 each, debounced levels, active-low, for the stopwatch FSM.
REQ-007 SHALL have ports pulso1..pulso4, output, 1 each, active-high single-cycle press strobes.

Function
REQ-008 SHALL implement four identical, fully independent channels, n = 1..4; no channel affects another.
REQ-009 SHALL pass each btnN through a two-flop synchronizer (sync1 then sync2) before any other use.
REQ-010 SHALL hold a per-channel registered stable level, which drives btnN_limpo directly.
REQ-011 SHALL, while sync2 equals the stable level, load the channel counter with 0 every cycle.
REQ-012 SHALL, while sync2 differs from the stable level and counter < DEBOUNCE_CYCLES-1, increment the counter by 1.
REQ-013 SHALL, when sync2 differs from the stable level and counter == DEBOUNCE_CYCLES-1, load the stable level with sync2 and clear the counter in the same edge.
REQ-014 SHALL, for a raw change held steady, update btnN_limpo on rising edge DEBOUNCE_CYCLES+2, counting the first edge that samples the new raw value as edge 1.
REQ-015 SHALL discard any raw excursion shorter than DEBOUNCE_CYCLES cycles at sync2: the counter returns to 0 and btnN_limpo does not change.
REQ-016 SHALL restart counting from 0 after any bounce back to the stable level; partial counts are never accumulated across bounces.
REQ-017 SHALL assert pulsoN, registered, on the same edge where the stable level goes 1->0, and deassert it on the next edge; exactly one cycle per accepted press.
REQ-018 SHALL never assert pulsoN on a release (stable level 0->1), or while a button is held.
REQ-019 SHALL never let the counter wrap; it saturates at DEBOUNCE_CYCLES-1 by construction of REQ-012/013.
REQ-020 SHALL process simultaneous presses on several channels in parallel, each producing its own pulse in the same cycle if timing matches.

Reset
REQ-021 SHALL, while rst=1, force sync1, sync2 and the stable level to 1 (released), counters to 0 and pulsoN to 0, regardless of clk.
REQ-022 SHALL give outputs btnN_limpo=1 and pulsoN=0 during and immediately after reset.
REQ-023 SHALL, on reset asserted mid-count or mid-pulse, abandon the count and drop the pulse immediately, with no pulse after release.
REQ-024 SHALL, when rst releases while a button is held low, produce a press acceptance and one pulse DEBOUNCE_CYCLES+2 edges after release.

Verification (DEBOUNCE_CYCLES=4, CNT_W=3)
REQ-025 SHALL cover a clean press: btn1 1->0 held -> btn1_limpo=0 at edge 6, pulso1=1 for exactly cycle 6->7, other channels unchanged.
REQ-026 SHALL cover a bounce: btn2 low 3 cycles, high 1, then low steady -> no change during the glitch; btn2_limpo=0 and one pulso2 six edges after the final fall.
REQ-027 SHALL cover a release: btn1 0->1 held after an accepted press -> btn1_limpo=1 at edge 6, pulso1 stays 0.
REQ-028 SHALL cover simultaneous presses: btn3 and btn4 fall in the same cycle -> pulso3 and pulso4 both high in the same single cycle.
REQ-029 SHALL cover reset mid-count: rst pulsed at edge 4 of a btn1 press -> btn1_limpo=1 and pulso1=0 immediately; acceptance 6 edges after rst falls.
REQ-030 SHALL cover a long hold: btn2 held low 100 cycles -> exactly one pulso2 and the counter never exceeds 3.
